// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the 3x3 convolution sequencer
package conv_pkg;

   localparam int PIX_W   = 4;
   localparam int TAPS    = 9;
   localparam int RES_W   = 16;
   localparam int DIM_MIN = 3;
   localparam int DIM_MAX = 32;
   localparam int VEC_W   = PIX_W * TAPS;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CONV,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } conv_state_t;

   function automatic logic dim_legal(input int unsigned d);
      return (d >= DIM_MIN) && (d <= DIM_MAX);
   endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - window position / tap counters and sample address generation
module conv_addr_gen
   import conv_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DIM_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic [DIM_W-1:0]  img_width,
   input  logic [DIM_W-1:0]  img_height,
   input  logic              fetch_step,
   input  logic              pos_step,
   output logic [ADDR_W-1:0] addr,
   output logic [3:0]        fetch_idx,
   output logic              issue,
   output logic              fetch_last,
   output logic              frame_last
);

   localparam int IX_W  = DIM_W + 1;
   localparam int LIN_W = 2 * DIM_W + 2;

   logic [DIM_W-1:0] w_q, h_q, r_q, c_q;
   logic [3:0]       f_q;
   logic [1:0]       kr_q, kc_q;
   logic             col_last, row_last;
   logic [IX_W-1:0]  row_ix, col_ix;
   logic [LIN_W-1:0] lin;

   assign col_last   = (c_q == w_q - DIM_W'(3));
   assign row_last   = (r_q == h_q - DIM_W'(3));
   assign frame_last = col_last && row_last;

   // kr/kc track k/3 and k%3 incrementally so no divider is needed
   assign row_ix = IX_W'(r_q) + IX_W'(kr_q);
   assign col_ix = IX_W'(c_q) + IX_W'(kc_q);
   assign lin    = LIN_W'(row_ix) * LIN_W'(w_q) + LIN_W'(col_ix);
   assign addr   = ADDR_W'(lin);

   assign fetch_idx  = f_q;
   assign issue      = (f_q != 4'(TAPS));
   assign fetch_last = (f_q == 4'(TAPS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q  <= '0;
         h_q  <= '0;
         r_q  <= '0;
         c_q  <= '0;
         f_q  <= '0;
         kr_q <= '0;
         kc_q <= '0;
      end else if (frame_start) begin
         w_q  <= img_width;
         h_q  <= img_height;
         r_q  <= '0;
         c_q  <= '0;
         f_q  <= '0;
         kr_q <= '0;
         kc_q <= '0;
      end else begin
         if (fetch_step) begin
            if (f_q == 4'(TAPS)) begin
               f_q  <= '0;
               kr_q <= '0;
               kc_q <= '0;
            end else begin
               f_q <= f_q + 4'd1;
               if (kc_q == 2'd2) begin
                  kc_q <= '0;
                  kr_q <= kr_q + 2'd1;
               end else begin
                  kc_q <= kc_q + 2'd1;
               end
            end
         end
         if (pos_step) begin
            if (col_last) begin
               c_q <= '0;
               r_q <= r_q + DIM_W'(1);
            end else begin
               c_q <= c_q + DIM_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - sequencer feeding 3x3 windows to mult_add and forwarding results
module conv_sched
   import conv_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DIM_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DIM_W-1:0]  img_width,
   input  logic [DIM_W-1:0]  img_height,
   input  logic [35:0]       coeff_cfg,
   output logic              samp_ren,
   output logic [ADDR_W-1:0] samp_raddr,
   input  logic [3:0]        samp_rdata,
   output logic [35:0]       sample_out,
   output logic [35:0]       coeff_out,
   output logic              conv_en,
   input  logic [15:0]       result_in,
   input  logic              result_ready,
   output logic [15:0]       res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   conv_state_t       state;
   logic              legal;
   logic              frame_start;
   logic              fetch_step;
   logic              pos_step;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        fetch_idx;
   logic              issue, fetch_last, frame_last;

   assign legal       = dim_legal(int'(img_width)) && dim_legal(int'(img_height));
   assign frame_start = (state == ST_IDLE) && start && legal;
   assign fetch_step  = (state == ST_FETCH);
   assign pos_step    = (state == ST_WRITE) && res_valid && res_ready && !abort;

   assign samp_ren   = (state == ST_FETCH) && issue;
   assign samp_raddr = samp_ren ? addr : '0;

   conv_addr_gen #(
      .ADDR_W(ADDR_W),
      .DIM_W (DIM_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .img_width  (img_width),
      .img_height (img_height),
      .fetch_step (fetch_step),
      .pos_step   (pos_step),
      .addr       (addr),
      .fetch_idx  (fetch_idx),
      .issue      (issue),
      .fetch_last (fetch_last),
      .frame_last (frame_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         sample_out <= '0;
         coeff_out  <= '0;
         conv_en    <= 1'b0;
         res_data   <= '0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         conv_en <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         if (abort && state != ST_IDLE) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     if (legal) begin
                        coeff_out <= coeff_cfg;
                        busy      <= 1'b1;
                        state     <= ST_FETCH;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               ST_FETCH: begin
                  // read data lags its issue by one cycle, so idx n lands in nibble n-1
                  for (int i = 0; i < TAPS; i++) begin
                     if (fetch_idx == 4'(i + 1))
                        sample_out[i*PIX_W +: PIX_W] <= samp_rdata;
                  end
                  if (fetch_last) begin
                     conv_en <= 1'b1;
                     state   <= ST_CONV;
                  end
               end
               ST_CONV: state <= ST_WAIT;
               ST_WAIT: begin
                  if (result_ready) begin
                     res_data  <= result_in;
                     res_valid <= 1'b1;
                     state     <= ST_WRITE;
                  end
               end
               ST_WRITE: begin
                  if (res_ready) begin
                     res_valid <= 1'b0;
                     if (frame_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                     end else begin
                        state <= ST_FETCH;
                     end
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - scoreboard bench for conv_sched with memory and mult_add models
module tb_conv_sched;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [5:0]  img_width, img_height;
   logic [35:0] coeff_cfg;
   logic        samp_ren;
   logic [9:0]  samp_raddr;
   logic [3:0]  samp_rdata;
   logic [35:0] sample_out, coeff_out;
   logic        conv_en;
   logic [15:0] result_in;
   logic        result_ready;
   logic [15:0] res_data;
   logic        res_valid, res_ready, busy, done, err;

   always #5 clk = ~clk;

   conv_sched #(.ADDR_W(10), .DIM_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .img_width(img_width), .img_height(img_height), .coeff_cfg(coeff_cfg),
      .samp_ren(samp_ren), .samp_raddr(samp_raddr), .samp_rdata(samp_rdata),
      .sample_out(sample_out), .coeff_out(coeff_out), .conv_en(conv_en),
      .result_in(result_in), .result_ready(result_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .done(done), .err(err)
   );

   logic [3:0] mem [0:1023];
   int unsigned exp_q[$];
   int vectors = 0, miscompares = 0;
   int done_cnt = 0, read_cnt = 0;
   int mult_lat = 1;
   bit hold_ready = 1'b0, bp_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int dot(input logic [35:0] s, input logic [35:0] c);
      int acc = 0;
      for (int k = 0; k < 9; k++) acc += int'(s[k*4 +: 4]) * int'(c[k*4 +: 4]);
      return acc & 32'hFFFF;
   endfunction

   // reference: every valid-mode window in raster order, straight from the image
   task automatic push_model(input int w, input int h, input logic [35:0] cf);
      for (int r = 0; r <= h - 3; r++)
         for (int c = 0; c <= w - 3; c++) begin
            int acc = 0;
            for (int k = 0; k < 9; k++)
               acc += int'(mem[(r + k / 3) * w + c + k % 3]) * int'(cf[k*4 +: 4]);
            exp_q.push_back(acc % 65536);
         end
   endtask

   // sample memory: one-cycle read latency
   initial forever begin
      logic ren; logic [9:0] ad;
      @(negedge clk); ren = samp_ren; ad = samp_raddr;
      @(posedge clk); #1;
      if (ren) samp_rdata = mem[ad];
   end

   // mult_add: result_ready mult_lat cycles after conv_en
   initial forever begin
      logic ce; int dv; int cnt;
      @(negedge clk);
      ce = conv_en; dv = dot(sample_out, coeff_out);
      if (rst) begin ce = 1'b0; cnt = 0; end
      @(posedge clk); #1;
      result_ready = 1'b0;
      if (ce) begin
         result_in = 16'(dv);
         if (mult_lat == 1) result_ready = 1'b1; else cnt = mult_lat - 1;
      end else if (cnt != 0) begin
         cnt--;
         if (cnt == 0) result_ready = 1'b1;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      res_ready = hold_ready ? 1'b0 : (bp_en ? ($urandom_range(0, 2) != 0) : 1'b1);
   end

   // monitor: pops the scoreboard on every transfer
   initial forever begin
      bit stall_v; logic [15:0] stall_d;
      @(negedge clk);
      if (rst) begin
         stall_v = 1'b0;
      end else begin
         if (samp_ren) read_cnt++;
         if (done) begin
            done_cnt++;
            chk("busy_low_at_done", busy, 0);
         end
         if (res_valid) chk("no_read_while_valid", samp_ren, 0);
         if (stall_v && res_valid) chk("res_data_stable", res_data, stall_d);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_result: got %0d, expected no result", res_data);
            end else begin
               chk("result", res_data, exp_q.pop_front());
            end
            stall_v = 1'b0;
         end else begin
            stall_v = res_valid; stall_d = res_data;
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_sample_out"}, sample_out, 0);
      chk({tag, "_coeff_out"}, coeff_out, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_ctrl"}, {samp_ren, samp_raddr, conv_en, res_valid, busy, done, err}, 0);
   endtask

   task automatic fill_mod16();
      for (int i = 0; i < 1024; i++) mem[i] = 4'(i % 16);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
   endtask

   task automatic launch(input int w, input int h, input logic [35:0] cf);
      img_width = 6'(w); img_height = 6'(h); coeff_cfg = cf;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int w, input int h,
                            input logic [35:0] cf, input bit use_model);
      int d0, outs, i;
      bit got;
      outs = (w - 2) * (h - 2);
      if (use_model) push_model(w, h, cf);
      read_cnt = 0; d0 = done_cnt;
      launch(w, h, cf);
      chk({tag, "_busy_after_start"}, busy, 1);
      got = 1'b0;
      for (i = 0; i < outs * 60 + 100; i++) begin
         @(negedge clk);
         if (done_cnt != d0) begin got = 1'b1; break; end
      end
      if (!got) begin
         vectors++; miscompares++;
         $display("FAIL %s_timeout: no done within budget, got %0d results left", tag, exp_q.size());
      end
      repeat (3) @(negedge clk);
      chk({tag, "_done_once"}, done_cnt - d0, 1);
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_reads"}, read_cnt, 9 * outs);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, w, h;
      bit got;
      logic [35:0] cf;
      rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
      img_width = '0; img_height = '0; coeff_cfg = '0;
      samp_rdata = '0; result_in = '0; result_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // W=4,H=3 ramp image, unit coefficients
      fill_mod16();
      exp_q.push_back(45); exp_q.push_back(54);
      run_frame("case1", 4, 3, 36'h111111111, 1'b0);

      // saturated pixels and coefficients
      for (int i = 0; i < 1024; i++) mem[i] = 4'hF;
      exp_q.push_back(2025);
      run_frame("case2", 3, 3, 36'hFFFFFFFFF, 1'b0);

      // sink stall on the first result
      fill_mod16();
      exp_q.push_back(45); exp_q.push_back(54);
      hold_ready = 1'b1; d0 = done_cnt;
      launch(4, 3, 36'h111111111);
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (res_valid) begin got = 1'b1; break; end
      end
      chk("stall_valid_seen", got, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_res_valid", res_valid, 1);
         chk("stall_res_data", res_data, 45);
         chk("stall_samp_ren", samp_ren, 0);
      end
      hold_ready = 1'b0;
      for (int i = 0; i < 80 && done_cnt == d0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("stall_done_once", done_cnt - d0, 1);
      chk("stall_queue_empty", exp_q.size(), 0);
      exp_q.delete();

      // illegal dimensions rejected
      read_cnt = 0;
      launch(2, 5, 36'h111111111);
      chk("err_w2_pulse", err, 1);
      chk("err_w2_busy", busy, 0);
      @(posedge clk); #1;
      chk("err_w2_one_cycle", err, 0);
      launch(10, 33, 36'h111111111);
      chk("err_h33_pulse", err, 1);
      repeat (5) @(negedge clk);
      chk("err_no_reads", read_cnt, 0);
      chk("err_busy_low", busy, 0);

      // configuration changes mid-frame are ignored
      fill_mod16();
      exp_q.push_back(45); exp_q.push_back(54);
      fork
         run_frame("cfgchg", 4, 3, 36'h111111111, 1'b0);
         begin
            repeat (6) @(posedge clk);
            #2 coeff_cfg = 36'h9A5C3E71F; img_width = 6'd2; img_height = 6'd40;
         end
      join

      // abort during the fetch of the second output
      exp_q.push_back(45);
      d0 = done_cnt;
      launch(4, 3, 36'h111111111);
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (res_valid && res_ready) begin got = 1'b1; break; end
      end
      chk("abort_first_xfer", got, 1);
      repeat (3) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_res_valid", res_valid, 0);
      chk("abort_samp_ren", samp_ren, 0);
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_queue_empty", exp_q.size(), 0);
      exp_q.delete();

      exp_q.push_back(45); exp_q.push_back(54);
      run_frame("rerun_abort", 4, 3, 36'h111111111, 1'b0);

      // reset while waiting for mult_add
      mult_lat = 3; d0 = done_cnt;
      launch(4, 3, 36'h111111111);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (conv_en) begin got = 1'b1; break; end
      end
      chk("rst_conv_seen", got, 1);
      @(posedge clk); #1 rst = 1'b1;
      #1 check_zero("midrst");
      @(posedge clk); #1 rst = 1'b0;
      mult_lat = 1;
      repeat (15) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_busy", busy, 0);

      exp_q.push_back(45); exp_q.push_back(54);
      run_frame("rerun_rst", 4, 3, 36'h111111111, 1'b0);

      // randomized frames with backpressure and variable compute latency
      bp_en = 1'b1;
      for (int n = 0; n < 6; n++) begin
         w = $urandom_range(3, 10); h = $urandom_range(3, 10);
         cf = {4'($urandom), 32'($urandom)};
         mult_lat = $urandom_range(1, 3);
         fill_rand();
         run_frame("rand", w, h, cf, 1'b1);
      end
      bp_en = 1'b0; mult_lat = 1;

      // largest legal dimensions
      fill_rand();
      run_frame("wmax", 32, 3, {4'($urandom), 32'($urandom)}, 1'b1);
      fill_rand();
      run_frame("hmax", 3, 32, {4'($urandom), 32'($urandom)}, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
